nic8_sequencer: RTL

- Control unit for the nic8 register/datapath block: owns the fetch/execute state machine and drives the 14-bit `Control` word every cycle from IR, carry flag and state.
- Adds run/halt/single-step handshake for the debug front panel, a memory-ready stall, and a retired-instruction counter.
- Sits between the debug controller, memory and the registers block.
- Every instruction takes exactly 2 unstalled cycles: FETCH then EXEC.

---
 rtl/nic8_pkg.sv | 49 ++++
 rtl/nic8_exec_decode.sv | 55 +++++
 rtl/nic8_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/nic8_pkg.sv
// Shared constants for the nic8 control unit: control-word bit positions,
// instruction field codes and the sequencer state type.
package nic8_pkg;

    localparam int CTRL_W = 14;

    localparam int CB_LOADIR  = 13;
    localparam int CB_LOADPC  = 12;
    localparam int CB_LOADA   = 11;
    localparam int CB_LOADB   = 10;
    localparam int CB_LOADX   = 9;
    localparam int CB_OUT     = 8;
    localparam int CB_STORE   = 7;
    localparam int CB_ASSERTM = 6;
    localparam int CB_ASSERTE = 5;
    localparam int CB_ASSERTA = 4;
    localparam int CB_ASSERTX = 3;
    localparam int CB_IMM     = 2;
    localparam int CB_JUMP    = 1;
    localparam int CB_SUB     = 0;

    localparam logic [2:0] DST_A     = 3'd0;
    localparam logic [2:0] DST_B     = 3'd1;
    localparam logic [2:0] DST_X     = 3'd2;
    localparam logic [2:0] DST_OUT   = 3'd3;
    localparam logic [2:0] DST_JMP   = 3'd4;
    localparam logic [2:0] DST_JC    = 3'd5;
    localparam logic [2:0] DST_STORE = 3'd6;
    localparam logic [2:0] DST_HALT  = 3'd7;

    localparam logic [1:0] SRC_IMM = 2'd0;
    localparam logic [1:0] SRC_ALU = 2'd1;
    localparam logic [1:0] SRC_A   = 2'd2;
    localparam logic [1:0] SRC_X   = 2'd3;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic logic [CTRL_W-1:0] cb_bit(input int idx);
        return {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
    endfunction

    localparam logic [CTRL_W-1:0] FETCH_WORD =
        cb_bit(CB_LOADIR) | cb_bit(CB_ASSERTM) | cb_bit(CB_IMM);

endpackage

// File: rtl/nic8_exec_decode.sv
// Combinational decode of the instruction opcode bits into the EXEC-phase
// control word, plus flags for HALT and memory use.
module nic8_exec_decode
    import nic8_pkg::*;
(
    input  logic [5:0]        i_op,
    input  logic              i_flag_carry,
    output logic [CTRL_W-1:0] o_word,
    output logic              o_is_halt,
    output logic              o_uses_mem
);

    logic [2:0] w_dest;
    logic [1:0] w_src;

    assign w_dest = i_op[5:3];
    assign w_src  = i_op[2:1];

    always_comb begin
        o_word = '0;
        // HALT only drives the bus for the immediate form, so PC still skips the operand
        if (w_dest != DST_HALT || w_src == SRC_IMM) begin
            case (w_src)
                SRC_IMM: begin
                    o_word[CB_ASSERTM] = 1'b1;
                    o_word[CB_IMM]     = 1'b1;
                end
                SRC_ALU: o_word[CB_ASSERTE] = 1'b1;
                SRC_A:   o_word[CB_ASSERTA] = 1'b1;
                default: o_word[CB_ASSERTX] = 1'b1;
            endcase
        end
        case (w_dest)
            DST_A:     o_word[CB_LOADA] = 1'b1;
            DST_B:     o_word[CB_LOADB] = 1'b1;
            DST_X:     o_word[CB_LOADX] = 1'b1;
            DST_OUT:   o_word[CB_OUT]   = 1'b1;
            DST_JMP: begin
                o_word[CB_LOADPC] = 1'b1;
                o_word[CB_JUMP]   = 1'b1;
            end
            DST_JC: begin
                o_word[CB_LOADPC] = 1'b1;
                o_word[CB_JUMP]   = i_flag_carry;
            end
            DST_STORE: o_word[CB_STORE] = 1'b1;
            default: ;
        endcase
        o_word[CB_SUB] = i_op[0];
    end

    assign o_is_halt  = (w_dest == DST_HALT);
    assign o_uses_mem = o_word[CB_ASSERTM] | o_word[CB_STORE];

endmodule

// File: rtl/nic8_sequencer.sv
// nic8 fetch/execute sequencer with run/step/halt debug handshake,
// memory-ready stall and retired-instruction counter.
module nic8_sequencer
    import nic8_pkg::*;
#(
    parameter bit START_RUNNING = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        ir,
    input  logic              flagCarry,
    input  logic              mem_ready,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    output logic [CTRL_W-1:0] controlBits,
    output logic              halted,
    output logic              fetch_phase,
    output logic [CNT_W-1:0]  instr_count
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_step_mode, w_step_mode_next;
    logic              r_halt_pending, w_halt_pending_next;
    logic [CNT_W-1:0]  r_count;
    logic [CTRL_W-1:0] w_exec_word, w_word;
    logic              w_is_halt, w_uses_mem, w_stall, w_retire;
    logic              w_unused_ir;

    assign w_unused_ir = &{1'b0, ir[1:0]};

    nic8_exec_decode u_decode (
        .i_op         (ir[7:2]),
        .i_flag_carry (flagCarry),
        .o_word       (w_exec_word),
        .o_is_halt    (w_is_halt),
        .o_uses_mem   (w_uses_mem)
    );

    always_comb begin
        w_state_next        = r_state;
        w_step_mode_next    = r_step_mode;
        w_halt_pending_next = r_halt_pending | halt_req;
        w_word              = '0;
        w_stall             = 1'b0;
        w_retire            = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_word  = FETCH_WORD;
                w_stall = !mem_ready;
                if (!w_stall) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_word  = w_exec_word;
                w_stall = w_uses_mem && !mem_ready;
                if (!w_stall) begin
                    w_retire = 1'b1;
                    // halt_req arriving on the boundary cycle itself still counts
                    if (w_is_halt || r_halt_pending || halt_req || r_step_mode) begin
                        w_state_next        = ST_HALTED;
                        w_halt_pending_next = 1'b0;
                        w_step_mode_next    = 1'b0;
                    end else begin
                        w_state_next = ST_FETCH;
                    end
                end
            end
            default: begin
                w_halt_pending_next = 1'b0;
                if (run) begin
                    w_state_next     = ST_FETCH;
                    w_step_mode_next = 1'b0;
                end else if (step) begin
                    w_state_next     = ST_FETCH;
                    w_step_mode_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= START_RUNNING ? ST_FETCH : ST_HALTED;
            r_step_mode    <= 1'b0;
            r_halt_pending <= 1'b0;
            r_count        <= '0;
        end else begin
            r_state        <= w_state_next;
            r_step_mode    <= w_step_mode_next;
            r_halt_pending <= w_halt_pending_next;
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign controlBits = (w_stall || !reset) ? '0 : w_word;
    assign halted      = (r_state == ST_HALTED);
    assign fetch_phase = (r_state == ST_FETCH);
    assign instr_count = r_count;

endmodule
